input_sampler: RTL
==================

Name: input_sampler

Overview:
- Player-input front end. Produces the per-player input vectors that game_logic consumes.
- Takes raw, active-low, asynchronous button pins for both players and, for each bit: synchronizes it, debounces it, and accumulates press edges.
- Presents a frame-coherent snapshot to game_logic once per frame_tick, so game logic sees stable inputs for a whole frame.

Parameters:
- INPUT_DEPTH, 5, buttons per player. Value comes from params.vh.
- DEBOUNCE_CYCLES, 500000, consecutive sys_clk cycles a new level must persist before it is accepted (10 ms at 50 MHz). Must be >= 2.
- DB_CNT_WIDTH, 19, debounce counter width. Must satisfy 2^DB_CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- sys_clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low.
- p1_raw  input  INPUT_DEPTH  player 1 button pins; active-low, asynchronous.
- p2_raw  input  INPUT_DEPTH  player 2 button pins; active-low, asynchronous.
- frame_tick  input  1  one-cycle pulse at start of vertical blank, synchronous to sys_clk.
- p1_inputs  output  INPUT_DEPTH  player 1 held-button snapshot; active-high.
- p2_inputs  output  INPUT_DEPTH  player 2 held-button snapshot; active-high.
- p1_pressed  output  INPUT_DEPTH  player 1 buttons newly pressed since the previous snapshot.
- p2_pressed  output  INPUT_DEPTH  player 2 buttons newly pressed since the previous snapshot.
- inputs_valid  output  1  one-cycle pulse; snapshot registers were updated this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - Sync flops go to 1 (released).
  - Debounced levels, counters, accumulators, all outputs and inputs_valid go to 0.
  - frame_tick is ignored while in reset.
- Synchronizer: two flops per bit on the raw pin. The synced level is inverted to active-high internally.
- Debouncer, per bit, with a stable level and a counter:
  - If synced == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
  - Else: counter <= counter+1.
  - Any glitch back to the stable level restarts the count.
  - Latency from a raw edge to the stable change is exactly 2+DEBOUNCE_CYCLES cycles.
- Edge detect: rise = stable goes 0->1 on this cycle. Only press edges are tracked; release edges are not.
- Press accumulator, per bit:
  - Sticky-set on rise.
  - Cleared when a snapshot is taken.
  - A tap shorter than one frame, but longer than the debounce time, is never lost.
- Snapshot, on the cycle frame_tick=1 (registered, visible the following cycle):
  - pN_inputs <= current stable vector.
  - pN_pressed <= accumulator OR rise-this-cycle.
  - Accumulator <= 0.
  - Simultaneous rise and frame_tick: the edge goes into this snapshot, not the next one.
- inputs_valid: 1 on the cycle after frame_tick, otherwise 0.
  - Back-to-back frame_tick pulses give back-to-back valids; the second pressed vector contains only edges from the intervening cycle.
- Holding: outputs hold between snapshots regardless of pin activity.
- Independence: the two players and all bits are fully independent. No priority or cross-coupling.
- Reset mid-operation: debounce counts and pending presses are discarded. After release, the first snapshot reflects only post-reset activity.
- No combinational path from any input to any output.

Decomposition:
- params.vh holds:
  - INPUT_DEPTH.
  - Button index constants: BTN_LEFT=0, BTN_RIGHT=1, BTN_JUMP=2, BTN_ATTACK=3, BTN_BLOCK=4.
  - Default DEBOUNCE_CYCLES.
- Sub-module button_debouncer: one bit, containing the synchronizer, counter, stable level and rise output. input_sampler instantiates it 2*INPUT_DEPTH times via generate. The accumulator and snapshot logic stay in input_sampler.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset values: hold rst=0, toggle raw pins and pulse frame_tick -> all outputs 0, inputs_valid never asserts. Release rst and pulse frame_tick -> inputs_valid=1 one cycle later with all vectors 0.
- Debounce latency: p1_raw[BTN_JUMP] 1->0 held -> internal stable rises exactly 6 cycles later. Next frame_tick -> p1_inputs=5'b00100, p1_pressed=5'b00100. Following frame_tick with the button still held -> p1_inputs=5'b00100, p1_pressed=0.
- Glitch rejection: p2_raw[BTN_ATTACK] low for 3 cycles, then high -> no change. Next snapshot has p2_inputs=0, p2_pressed=0.
- Short tap within frame: p1_raw[BTN_LEFT] low 10 cycles, released well before frame_tick -> p1_inputs=0, p1_pressed=5'b00001.
- Simultaneous events: stable rise on p2 BTN_BLOCK on the same cycle as frame_tick -> that snapshot has p2_pressed[4]=1. Next snapshot has p2_pressed[4]=0.
- Reset mid-debounce: raw low for 3 cycles, assert rst, release with raw still low -> stable rises exactly 6 cycles after release (count restarted).

Source files
------------

// File: rtl/input_sampler_pkg.sv
// Shared constants for the player-input front end: button map and default sizing.
package input_sampler_pkg;

    localparam int INPUT_DEPTH_DEF     = 5;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int DB_CNT_WIDTH_DEF    = 19;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_JUMP   = 2;
    localparam int BTN_ATTACK = 3;
    localparam int BTN_BLOCK  = 4;

endpackage

// File: rtl/input_sampler_button_debouncer.sv
// One button: two-flop synchronizer, persistence-count debouncer, press-edge pulse.
module button_debouncer
    import input_sampler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DB_CNT_WIDTH    = DB_CNT_WIDTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw_n,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [DB_CNT_WIDTH-1:0] CNT_LAST = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_stable;
    logic                    r_stable_d;
    logic [DB_CNT_WIDTH-1:0] r_cnt;
    logic                    w_synced;

    // Pins are active-low; the synchronizer resets to the released level.
    assign w_synced = ~r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_raw_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= w_synced;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // High for the single cycle in which the debounced level is newly pressed.
    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_d;

endmodule

// File: rtl/input_sampler.sv
// Two-player input front end: per-bit debouncers, sticky press accumulators and
// a frame-coherent snapshot taken on frame_tick.
module input_sampler
    import input_sampler_pkg::*;
#(
    parameter int INPUT_DEPTH     = INPUT_DEPTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DB_CNT_WIDTH    = DB_CNT_WIDTH_DEF
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic [INPUT_DEPTH-1:0] p1_raw,
    input  logic [INPUT_DEPTH-1:0] p2_raw,
    input  logic                   frame_tick,
    output logic [INPUT_DEPTH-1:0] p1_inputs,
    output logic [INPUT_DEPTH-1:0] p2_inputs,
    output logic [INPUT_DEPTH-1:0] p1_pressed,
    output logic [INPUT_DEPTH-1:0] p2_pressed,
    output logic                   inputs_valid,
    output logic [INPUT_DEPTH-1:0] dbg_p1_stable,
    output logic [INPUT_DEPTH-1:0] dbg_p2_stable
);

    logic [INPUT_DEPTH-1:0] w_p1_stable;
    logic [INPUT_DEPTH-1:0] w_p2_stable;
    logic [INPUT_DEPTH-1:0] w_p1_rise;
    logic [INPUT_DEPTH-1:0] w_p2_rise;

    logic [INPUT_DEPTH-1:0] r_p1_acc;
    logic [INPUT_DEPTH-1:0] r_p2_acc;
    logic [INPUT_DEPTH-1:0] r_p1_inputs;
    logic [INPUT_DEPTH-1:0] r_p2_inputs;
    logic [INPUT_DEPTH-1:0] r_p1_pressed;
    logic [INPUT_DEPTH-1:0] r_p2_pressed;
    logic                   r_valid;

    for (genvar g = 0; g < INPUT_DEPTH; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_CNT_WIDTH    (DB_CNT_WIDTH)
        ) u_p1 (
            .i_clk    (sys_clk),
            .i_rst_n  (rst),
            .i_raw_n  (p1_raw[g]),
            .o_stable (w_p1_stable[g]),
            .o_rise   (w_p1_rise[g])
        );
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_CNT_WIDTH    (DB_CNT_WIDTH)
        ) u_p2 (
            .i_clk    (sys_clk),
            .i_rst_n  (rst),
            .i_raw_n  (p2_raw[g]),
            .o_stable (w_p2_stable[g]),
            .o_rise   (w_p2_rise[g])
        );
    end

    // A rise coinciding with frame_tick lands in this snapshot, so the
    // accumulator is cleared rather than set on that cycle.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_p1_acc     <= '0;
            r_p2_acc     <= '0;
            r_p1_inputs  <= '0;
            r_p2_inputs  <= '0;
            r_p1_pressed <= '0;
            r_p2_pressed <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= frame_tick;
            if (frame_tick) begin
                r_p1_inputs  <= w_p1_stable;
                r_p2_inputs  <= w_p2_stable;
                r_p1_pressed <= r_p1_acc | w_p1_rise;
                r_p2_pressed <= r_p2_acc | w_p2_rise;
                r_p1_acc     <= '0;
                r_p2_acc     <= '0;
            end else begin
                r_p1_acc <= r_p1_acc | w_p1_rise;
                r_p2_acc <= r_p2_acc | w_p2_rise;
            end
        end
    end

    // inputs_valid is a one-cycle strobe with no ready: the snapshot vectors
    // changed on this cycle and hold until the next strobe.
    assign p1_inputs     = r_p1_inputs;
    assign p2_inputs     = r_p2_inputs;
    assign p1_pressed    = r_p1_pressed;
    assign p2_pressed    = r_p2_pressed;
    assign inputs_valid  = r_valid;
    assign dbg_p1_stable = w_p1_stable;
    assign dbg_p2_stable = w_p2_stable;

endmodule
